// File: rtl/gray_wr_ptr.sv
// rtl/gray_wr_ptr.sv - write-side Gray pointer, full flag and level for a dual-clock FIFO
//
// Purpose:
//   Keeps the binary write pointer (ADDR_WIDTH+1 bits, the MSB is the wrap bit).
//   Exports a registered Gray copy of the pointer to the read domain.
//   Compares the pointer against the read-side Gray pointer to produce registered
//   full and occupancy outputs.
//
// Configuration macro: GRAY_WR_PTR_SYNC_EN
//   Defined   : rd_gray_i passes through a SYNC_STAGES-deep flop chain in clk_i.
//   Undefined : rd_gray_i is used directly and must already be synchronous to clk_i.
//
// Ports:
//   clk_i      in   1             clock, rising edge
//   rst_i      in   1             synchronous active-high reset, priority over inc_i
//   inc_i      in   1             write request, accepted when inc_i & ~full_o
//   rd_gray_i  in   ADDR_WIDTH+1  read-domain Gray pointer
//   wr_addr_o  out  ADDR_WIDTH    RAM write address
//   wr_gray_o  out  ADDR_WIDTH+1  registered Gray write pointer
//   full_o     out  1             registered FIFO-full flag
//   level_o    out  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH

module bin_to_gray #(
   parameter int DATA_WIDTH = 5
) (
   input  logic [DATA_WIDTH-1:0] bin_i,
   output logic [DATA_WIDTH-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

module gray_wr_ptr #(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  inc_i,
   input  logic [ADDR_WIDTH:0]   rd_gray_i,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [ADDR_WIDTH:0]   wr_gray_o,
   output logic                  full_o,
   output logic [ADDR_WIDTH:0]   level_o
);
   localparam int AW = ADDR_WIDTH;

   if (ADDR_WIDTH < 2 || SYNC_STAGES < 2) begin : g_param_check
      $error("gray_wr_ptr: ADDR_WIDTH and SYNC_STAGES must both be >= 2");
   end

   logic [AW:0] r_ptr_bin;
   logic [AW:0] r_wr_gray;
   logic        r_full;
   logic [AW:0] r_level;

   logic        w_accept;
   logic [AW:0] w_ptr_nxt;
   logic [AW:0] w_gray_nxt;
   logic [AW:0] w_rs;
   logic [AW:0] w_rs_bin;
   logic        w_full_nxt;
   logic [AW:0] w_level_nxt;

   function automatic logic [AW:0] gray_to_bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

`ifdef GRAY_WR_PTR_SYNC_EN
   logic [AW:0] r_sync [SYNC_STAGES];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= rd_gray_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   assign w_rs = r_sync[SYNC_STAGES-1];
`else
   assign w_rs = rd_gray_i;
`endif

   assign w_accept  = inc_i & ~r_full;
   assign w_ptr_nxt = r_ptr_bin + {{AW{1'b0}}, w_accept};

   bin_to_gray #(
      .DATA_WIDTH (AW + 1)
   ) u_bin_to_gray (
      .bin_i  (w_ptr_nxt),
      .gray_o (w_gray_nxt)
   );

   // Full when the pointers differ only in the wrap bit: in Gray code that is
   // the top two bits inverted and the rest equal.
   assign w_rs_bin    = gray_to_bin(w_rs);
   assign w_full_nxt  = (w_gray_nxt == {~w_rs[AW:AW-1], w_rs[AW-2:0]});
   assign w_level_nxt = w_ptr_nxt - w_rs_bin;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr_bin <= '0;
         r_wr_gray <= '0;
         r_full    <= 1'b0;
         r_level   <= '0;
      end else begin
         r_ptr_bin <= w_ptr_nxt;
         r_wr_gray <= w_gray_nxt;
         r_full    <= w_full_nxt;
         r_level   <= w_level_nxt;
      end
   end

   assign wr_addr_o = r_ptr_bin[AW-1:0];
   assign wr_gray_o = r_wr_gray;
   assign full_o    = r_full;
   assign level_o   = r_level;
endmodule

// File: tb/tb_gray_wr_ptr.sv
// tb/tb_gray_wr_ptr.sv - randomized self-checking bench for gray_wr_ptr

module tb_gray_wr_ptr;
   localparam int AW = 4;
   localparam int SS = 2;
`ifdef GRAY_WR_PTR_SYNC_EN
   localparam int LAT = SS;
`else
   localparam int LAT = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          inc;
   logic [AW:0]   rd_gray;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_gray;
   logic          full;
   logic [AW:0]   level;

   gray_wr_ptr #(
      .ADDR_WIDTH  (AW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .inc_i     (inc),
      .rd_gray_i (rd_gray),
      .wr_addr_o (wr_addr),
      .wr_gray_o (wr_gray),
      .full_o    (full),
      .level_o   (level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference state: count of accepted writes mod 32, read counts seen per edge
   int m_wr    = 0;
   int m_level = 0;
   bit m_full  = 1'b0;
   int hist[$];
   int rd_pos  = 0;

   function automatic int to_gray(input int b);
      return (b ^ (b >> 1)) & 31;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit i, input int rc);
      int rs;
      rst     = r;
      inc     = i;
      rd_gray = 5'(to_gray(rc & 31));
      @(posedge clk);
      if (r) begin
         m_wr    = 0;
         m_level = 0;
         m_full  = 1'b0;
         hist.delete();
      end else begin
         hist.push_back(rc & 31);
         rs = (hist.size() > LAT) ? hist[hist.size() - 1 - LAT] : 0;
         if (hist.size() > 8) void'(hist.pop_front());
         if (i && !m_full) m_wr = (m_wr + 1) % 32;
         m_level = (m_wr - rs) & 31;
         m_full  = (m_level == 16);
      end
      #1;
      check("wr_addr", 32'(wr_addr), 32'(m_wr % 16));
      check("wr_gray", 32'(wr_gray), 32'(to_gray(m_wr)));
      check("full",    32'(full),    32'(m_full));
      check("level",   32'(level),   32'(m_level));
   endtask

   initial begin
      logic [AW:0] prev_gray;
      int          seen_full;
      rst = 1'b1; inc = 1'b0; rd_gray = '0;

      // reset state
      step(1'b1, 1'b0, 0);
      check("rst_gray",  32'(wr_gray), 32'd0);
      check("rst_level", 32'(level),   32'd0);

      // fill to full with the reader parked at 0
      for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 0);
      check("fill_gray",  32'(wr_gray), 32'b11000);
      check("fill_full",  32'(full),    32'd1);
      check("fill_level", 32'(level),   32'd16);
      check("fill_addr",  32'(wr_addr), 32'd0);

      // requests while full are ignored
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0);
      check("hold_gray",  32'(wr_gray), 32'b11000);
      check("hold_level", 32'(level),   32'd16);

      // one read frees a slot after the remote-pointer latency
      for (int k = 0; k < LAT + 1; k++) step(1'b0, 1'b0, 1);
      check("drain_full",  32'(full),  32'd0);
      check("drain_level", 32'(level), 32'd15);

      // 64 accepts with the reader tracking the writer
      step(1'b1, 1'b0, 0);
      seen_full = 0;
      for (int k = 0; k < 64; k++) begin
         prev_gray = wr_gray;
         step(1'b0, 1'b1, m_wr);
         check("hamming", 32'($countones(prev_gray ^ wr_gray)), 32'd1);
         if (full) seen_full++;
         if (k == 31) check("wrap_gray", 32'(wr_gray), 32'd0);
      end
      check("track_full_seen", 32'(seen_full), 32'd0);

      // random writes and reads
      step(1'b1, 1'b0, 0);
      rd_pos = 0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 2) == 0 && rd_pos != m_wr) rd_pos = (rd_pos + 1) % 32;
         step(1'b0, ($urandom_range(0, 3) != 0), rd_pos);
      end

      // reset mid-operation with inc asserted
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 9; k++) step(1'b0, 1'b1, 0);
      for (int k = 0; k < LAT; k++) step(1'b0, 1'b0, 0);
      check("pre_rst_level", 32'(level), 32'd9);
      step(1'b1, 1'b1, 0);
      check("mid_rst_addr",  32'(wr_addr), 32'd0);
      check("mid_rst_level", 32'(level),   32'd0);
      step(1'b0, 1'b1, 0);
      check("resume_addr",  32'(wr_addr), 32'd1);
      check("resume_level", 32'(level),   32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
